framebuffer_arbiter: RTL
========================

// Module: framebuffer_arbiter
// PURPOSE
//  Shares one single-port, double-buffered image RAM between two requesters: display scan-out
//  (image_controller read address) and the processor (read/write port).
//  Display reads always come from the front buffer; processor accesses always go to the back buffer.
//  Front/back swap is requested by the processor and is applied only at a vertical-sync edge,
//  so a frame is never torn.
// PARAMETERS
//  ADDR_W        19      pixel address width per buffer
//  DATA_W        8       pixel data width
//  FRAME_PIXELS  307200  valid pixels per buffer (640x480); address >= this is out of range
//  RD_LAT        1       RAM read latency in cycles, from mem_addr presented to mem_rdata valid (1..4)
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous reset, active-low
//  vsync        in   1         vertical sync from sync generator, active-low
//  disp_req     in   1         display read request, one read per cycle it is high
//  disp_addr    in   ADDR_W    display pixel address
//  disp_rvalid  out  1         display read data valid (1-cycle pulse)
//  disp_rdata   out  DATA_W    display read data
//  cpu_req      in   1         processor request; hold req/we/addr/wdata stable until cpu_ack
//  cpu_we       in   1         1 = write, 0 = read
//  cpu_addr     in   ADDR_W    processor pixel address (back buffer)
//  cpu_wdata    in   DATA_W    processor write data
//  cpu_ack      out  1         1-cycle pulse: request issued (or dropped if out of range)
//  cpu_rvalid   out  1         processor read data valid (1-cycle pulse)
//  cpu_rdata    out  DATA_W    processor read data
//  swap_req     in   1         1-cycle pulse requesting a front/back swap
//  swap_pending out  1         swap requested, waiting for vsync edge
//  front_sel    out  1         current front buffer index
//  mem_addr     out  ADDR_W+1  RAM address {buffer, pixel}
//  mem_we       out  1         RAM write enable
//  mem_wdata    out  DATA_W    RAM write data
//  mem_rdata    in   DATA_W    RAM read data, RD_LAT cycles after address
// BEHAVIOUR
//  Reset:
//  - All outputs are 0, including front_sel and swap_pending.
//  - The return-tag pipeline is cleared, so reads in flight at reset never return a valid pulse.
//  Arbitration, per cycle n (from that cycle's inputs):
//  - Display has absolute priority: disp_req=1 wins.
//  - Otherwise a CPU request wins when cpu_req=1 and cpu_ack=0 in cycle n.
//  - The ack-cycle mask means back-to-back CPU accesses issue at most every 2nd cycle.
//  Registered mem_* outputs, driven in cycle n+1:
//  - Display grant: mem_addr={front_sel,disp_addr}, mem_we=0.
//  - CPU grant: mem_addr={~front_sel,cpu_addr}, mem_we=cpu_we, mem_wdata=cpu_wdata; cpu_ack=1 in the same cycle.
//  - No grant: mem_we=0; mem_addr holds its last value.
//  Read return:
//  - An owner tag (none/disp/cpu plus a zero flag) travels through an RD_LAT+1 stage shift register.
//  - rvalid/rdata of the owner are registered and appear in cycle n+2+RD_LAT.
//  - Only the owner's rvalid pulses; the other rdata output holds its value.
//  Out of range (addr >= FRAME_PIXELS):
//  - Display read: no RAM access is issued; disp_rvalid still pulses, with disp_rdata=0, at the normal latency.
//  - CPU write: dropped (mem_we=0) but still acked.
//  - CPU read: acked; returns 0 with cpu_rvalid at the normal latency.
//  Swap:
//  - swap_req sets swap_pending. A vsync falling edge is detected via a registered copy of vsync.
//  - In the edge cycle, if swap_pending or swap_req: front_sel toggles and swap_pending clears (next edge).
//  - swap_req while already pending is ignored; it never produces a double toggle.
//  - A grant in the edge cycle uses the pre-toggle front_sel.
//  - Accesses already issued are unaffected, since their addresses are fixed.
//  No RAM access is ever issued with both requesters granted; mem_we is never 1 for a display grant.
// TESTING
//  Reset low mid-read (RD_LAT=1) -> all outputs 0; no rvalid ever follows for the dropped read.
//  disp_req=1 for 4 cycles + cpu_req held -> 4 display reads at {0,addr}, rvalid at n+3.
//    Then cpu_ack on the 5th issue cycle, mem_addr={1,cpu_addr}.
//  Continuous cpu write req, disp idle -> cpu_ack every 2nd cycle; mem_we=1 only in ack cycles.
//  swap_req mid-frame, vsync 1->0 later -> swap_pending=1 until the edge cycle; front_sel=1 after.
//    A second swap_req while pending causes only one toggle.
//  swap_req in the vsync-edge cycle -> front_sel toggles at that edge; swap_pending never seen high.
//  cpu read addr 307200 -> cpu_ack, no RAM access, cpu_rvalid=1 with cpu_rdata=0 at n+3.
//    disp_addr 307200 -> no RAM access, disp_rvalid=1 with disp_rdata=0 at n+3.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
// Shares one single-port, double-buffered image RAM between display scan-out
// and the processor. Display reads always come from the front buffer and have
// absolute priority. Processor accesses always go to the back buffer. A
// processor-requested front/back swap takes effect only on a vsync falling
// edge, so a displayed frame is never torn.
//
// Ports
//   clk, reset              system clock; asynchronous active-low reset
//   vsync                   vertical sync, active-low
//   disp_req, disp_addr     display read request (one read per cycle high)
//   disp_rvalid, disp_rdata display read return (1-cycle valid pulse)
//   cpu_req/we/addr/wdata   processor request, held stable until cpu_ack
//   cpu_ack                 request issued, or dropped when out of range
//   cpu_rvalid, cpu_rdata   processor read return (1-cycle valid pulse)
//   swap_req                1-cycle pulse requesting a front/back swap
//   swap_pending            swap waiting for the next vsync falling edge
//   front_sel               buffer currently scanned out
//   mem_addr/we/wdata       RAM request, address is {buffer, pixel}
//   mem_rdata               RAM read data, RD_LAT cycles after mem_addr
module framebuffer_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 307200,
  parameter int RD_LAT       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              front_sel,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One extra bit so FRAME_PIXELS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] FRAME_LIM = (ADDR_W+1)'(FRAME_PIXELS);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DISP = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;

  logic                  disp_oor;
  logic                  cpu_oor;
  logic                  disp_grant;
  logic                  cpu_grant;
  logic                  vsync_q;
  logic                  vsync_fall;
  logic [2:0]            new_tag;
  logic [RD_LAT:0][2:0]  tag_q;
  logic [1:0]            ret_own;
  logic                  ret_zero;

  always_comb begin
    disp_oor   = ({1'b0, disp_addr} >= FRAME_LIM);
    cpu_oor    = ({1'b0, cpu_addr} >= FRAME_LIM);
    disp_grant = disp_req;
    // cpu_ack high means this cycle's request was already issued last cycle.
    cpu_grant  = cpu_req && !cpu_ack && !disp_req;
    vsync_fall = vsync_q && !vsync;
    // Tag is {owner, zero}; zero marks an out-of-range read that returns 0.
    new_tag    = {OWN_NONE, 1'b0};
    if (disp_grant) begin
      new_tag = {OWN_DISP, disp_oor};
    end else if (cpu_grant && !cpu_we) begin
      new_tag = {OWN_CPU, cpu_oor};
    end
  end

  assign ret_own  = tag_q[RD_LAT][2:1];
  assign ret_zero = tag_q[RD_LAT][0];

  // RAM request port. Out-of-range accesses leave mem_addr untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      cpu_ack <= cpu_grant;
      if (disp_grant) begin
        if (!disp_oor) begin
          mem_addr <= {front_sel, disp_addr};
        end
      end else if (cpu_grant && !cpu_oor) begin
        mem_addr  <= {~front_sel, cpu_addr};
        mem_we    <= cpu_we;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Owner tags line up with mem_rdata after RD_LAT+1 stages; the return is
  // then registered once more.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q       <= '0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      if (ret_own == OWN_DISP) begin
        disp_rvalid <= 1'b1;
        disp_rdata  <= ret_zero ? '0 : mem_rdata;
      end else if (ret_own == OWN_CPU) begin
        cpu_rvalid <= 1'b1;
        cpu_rdata  <= ret_zero ? '0 : mem_rdata;
      end
    end
  end

  // Swap control. vsync_q resets low so a low vsync at reset release is not
  // mistaken for a falling edge. A swap_req landing in the edge cycle toggles
  // immediately without ever showing swap_pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q      <= 1'b0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vsync_fall) begin
        if (swap_pending || swap_req) begin
          front_sel <= ~front_sel;
        end
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule
